calc_keypad_alu: RTL and testbench
==================================

# calc_keypad_alu

Front-end and arithmetic core of the FPGA keypad calculator. It combines three functions: the 50 MHz clock divider, the 16-key active-low keypad encoder, and the signed 32-bit arithmetic unit with error detection. It sits between the board pins (clock, push-buttons) and the calculator interface FSM / segment driver, which consume `eBCD`, `ans` and the divided clock enables.

## Interface
- `SW_DIV_LOG2`, default 21: keypad sample period is 2^21 clocks.
- `FND_DIV_LOG2`, default 17: display scan period is 2^17 clocks.
- `ERR_CODE`, default 32'h00EE_0000: value placed on `ans` on error ("Error" glyph code).
- `clock_50m`  in  1  sole clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pb`  in  16  push-buttons, active-low (0 = pressed).
- `operand1`, `operand2`  in  32 each  signed two's-complement operands.
- `operator`  in  3  operation code: 1 `*`, 2 `/`, 3 `+`, 4 `-`, 5 `%`.
- `cal_enable`  in  1  one-clock strobe requesting a calculation.
- `sw_clk`, `fnd_clk`  out  1 each  square waves: divider counter bits SW_DIV_LOG2-1 and FND_DIV_LOG2-1.
- `sw_tick`, `fnd_tick`  out  1 each  one-clock enables, one per divided period.
- `eBCD`  out  5  encoded key: bit 4 = valid, bits 3:0 = key code; 5'h00 when idle.
- `clr_req`  out  1  one-clock soft-clear request.
- `ans`  out  32  signed result register.
- `ans_valid`  out  1  one-clock strobe when `ans` updates.
- `err`  out  1  sticky error flag for the last calculation.

## Operation
- Divider: a free-running counter, SW_DIV_LOG2 bits wide, that wraps.
  - `sw_tick` = low SW_DIV_LOG2 bits all ones.
  - `fnd_tick` = low FND_DIV_LOG2 bits all ones.
- Keypad: `~pb` is sampled into a register on `sw_tick`, which acts as the debounce interval.
- Key map, pb bit to eBCD:
  - bits 0,1,2 → 1,2,3 (5'h11–13); bit 3 `/` 5'h1B.
  - bits 4,5,6 → 4,5,6; bit 7 `*` 5'h1A.
  - bits 8,9,10 → 7,8,9; bit 11 `-` 5'h1D.
  - bit 12 `+` 5'h1C; bit 13 `0` 5'h10; bit 14 ANS 5'h1E; bit 15 `=` 5'h1F.
- A press is recognised when the new sample is non-zero and the previous sample was zero.
  - The lowest-index pressed bit wins.
  - `eBCD` carries its code for exactly one clock, then returns to 5'h00.
  - Held keys and releases produce nothing.
- Bits 14 and 15 newly pressed together produce `clr_req` for one clock, and no `eBCD`.
- ALU: on a clock where `cal_enable`=1, compute from the inputs sampled that clock.
  - Intermediate results are 64-bit signed.
  - `/` truncates toward zero; `%` takes the sign of the dividend.
- Error cases:
  - divisor 0 for `/` or `%`;
  - operator not in 1–5;
  - result outside −99999..999999 (the 6-digit display range).
- On error: `ans`=ERR_CODE and `err`=1. Otherwise `ans`=result and `err`=0.

## Timing
- Reset values:
  - counter, `sw_clk`, `fnd_clk`, `sw_tick`, `fnd_tick` = 0;
  - key sample registers = 0; `eBCD`=0; `clr_req`=0;
  - `ans`=0, `ans_valid`=0, `err`=0.
- `sw_tick` first fires at clock 2^SW_DIV_LOG2−1 after reset release.
- Key-to-`eBCD` latency: one clock after the `sw_tick` that samples the press. Worst case is 2^SW_DIV_LOG2 + 1 clocks.
- ALU latency: `ans`, `err` and `ans_valid` update on the edge that samples `cal_enable`, so they are visible one clock later.
- `cal_enable` on consecutive clocks: each strobe is computed, and the last one wins.
- Reset mid-operation clears everything immediately, including a pending key edge.

## Structure
- Shared package `calc_pkg` holds:
  - operator codes OP_MUL..OP_MOD;
  - eBCD key codes;
  - ERR_CODE;
  - display limits DISP_MAX=999999 and DISP_MIN=−99999.
- One natural sub-module, `calc_alu`: purely the arithmetic, range check and result register.
- Divider and keypad encoder stay inline in the top.

## Test plan
- Divider with SW_DIV_LOG2=4, FND_DIV_LOG2=2 → `fnd_tick` every 4 clocks, `sw_tick` every 16; `sw_clk` period is 16 clocks.
- Walk a single pressed bit across pb[0]..pb[15], releasing between presses → codes 11,12,13,1B,14,15,16,1A,17,18,19,1D,1C,10,1E,1F (hex), each exactly one clock wide. Holding a key produces no repeat.
- operand1=10, operand2=101 with ops 3,4,1,2,5 → 111, −91, 1010, 0, 10.
- operand1=−10, operand2=−101 with ops 3,4,1,2,5 → −111, 91, 1010, 0, −10.
- operand1=100000, operand2=−500 with ops 3,4,1,2,5 → 99500, 100500, ERR_CODE with `err`=1 (−50000000 is out of range), −200, 0.
- operand1=1023, operand2=0 → `+` gives 1023, `/` and `%` give ERR_CODE. pb[14]+pb[15] pressed together → `clr_req` pulse. Asserting `rst` low mid-count → all outputs 0.

Source files
------------

// File: rtl/calc_keypad_alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_pkg : operator codes, key codes and display limits for the calculator
// rev 1.0
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_DIV = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_MOD = 3'd5;

    localparam logic [4:0] KEY_NONE = 5'h00;
    localparam logic [4:0] KEY_0    = 5'h10;
    localparam logic [4:0] KEY_1    = 5'h11;
    localparam logic [4:0] KEY_2    = 5'h12;
    localparam logic [4:0] KEY_3    = 5'h13;
    localparam logic [4:0] KEY_4    = 5'h14;
    localparam logic [4:0] KEY_5    = 5'h15;
    localparam logic [4:0] KEY_6    = 5'h16;
    localparam logic [4:0] KEY_7    = 5'h17;
    localparam logic [4:0] KEY_8    = 5'h18;
    localparam logic [4:0] KEY_9    = 5'h19;
    localparam logic [4:0] KEY_MUL  = 5'h1A;
    localparam logic [4:0] KEY_DIV  = 5'h1B;
    localparam logic [4:0] KEY_ADD  = 5'h1C;
    localparam logic [4:0] KEY_SUB  = 5'h1D;
    localparam logic [4:0] KEY_ANS  = 5'h1E;
    localparam logic [4:0] KEY_EQ   = 5'h1F;

    localparam logic [31:0] ERR_CODE = 32'h00EE_0000;

    localparam logic signed [63:0] DISP_MAX = 64'sd999999;
    localparam logic signed [63:0] DISP_MIN = -64'sd99999;

    // Board wiring: push-button index to key code.
    function automatic logic [4:0] key_code(input logic [3:0] idx);
        logic [4:0] code;
        case (idx)
            4'd0:    code = KEY_1;
            4'd1:    code = KEY_2;
            4'd2:    code = KEY_3;
            4'd3:    code = KEY_DIV;
            4'd4:    code = KEY_4;
            4'd5:    code = KEY_5;
            4'd6:    code = KEY_6;
            4'd7:    code = KEY_MUL;
            4'd8:    code = KEY_7;
            4'd9:    code = KEY_8;
            4'd10:   code = KEY_9;
            4'd11:   code = KEY_SUB;
            4'd12:   code = KEY_ADD;
            4'd13:   code = KEY_0;
            4'd14:   code = KEY_ANS;
            default: code = KEY_EQ;
        endcase
        return code;
    endfunction

    // Scanning downward lets the lowest pressed index overwrite the others.
    function automatic logic [4:0] encode_keys(input logic [15:0] keys);
        logic [4:0] code;
        code = KEY_NONE;
        for (int i = 15; i >= 0; i--) begin
            if (keys[i]) code = key_code(4'(i));
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_keypad_alu_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_keypad_alu_if : operand/operator request and result bus of the ALU
// rev 1.0
// ---------------------------------------------------------------------------
interface calc_keypad_alu_if;

    logic signed [31:0] operand1;
    logic signed [31:0] operand2;
    logic        [2:0]  operator;
    logic               cal_enable;
    logic signed [31:0] ans;
    logic               ans_valid;
    logic               err;

    modport master (
        output operand1, operand2, operator, cal_enable,
        input  ans, ans_valid, err
    );

    modport slave (
        input  operand1, operand2, operator, cal_enable,
        output ans, ans_valid, err
    );

endinterface
`default_nettype wire

// File: rtl/calc_keypad_alu_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_alu : signed 32-bit arithmetic with 64-bit intermediates, range check
// and result register. rev 1.0
// ---------------------------------------------------------------------------
module calc_alu #(
    parameter logic [31:0] ERR_CODE = calc_pkg::ERR_CODE
) (
    input  wire logic          clock_50m,
    input  wire logic          rst,
    calc_keypad_alu_if.slave   bus
);
    import calc_pkg::*;

    logic signed [63:0] a_w;
    logic signed [63:0] b_w;
    logic signed [63:0] b_safe_w;
    logic signed [63:0] res_w;
    logic               div_zero_w;
    logic               err_d;
    logic        [31:0] ans_d;

    logic        [31:0] ans_q;
    logic               err_q;
    logic               ans_valid_q;

    always_comb begin
        a_w        = {{32{bus.operand1[31]}}, bus.operand1};
        b_w        = {{32{bus.operand2[31]}}, bus.operand2};
        div_zero_w = (bus.operand2 == 32'sd0);
        // Divisor forced to 1 on zero so the divider never sees 0; err masks the result.
        b_safe_w   = div_zero_w ? 64'sd1 : b_w;
        res_w      = 64'sd0;
        err_d      = 1'b0;
        case (bus.operator)
            OP_MUL:  res_w = a_w * b_w;
            OP_DIV:  begin res_w = a_w / b_safe_w; err_d = div_zero_w; end
            OP_ADD:  res_w = a_w + b_w;
            OP_SUB:  res_w = a_w - b_w;
            OP_MOD:  begin res_w = a_w % b_safe_w; err_d = div_zero_w; end
            default: err_d = 1'b1;
        endcase
        if ((res_w > DISP_MAX) || (res_w < DISP_MIN)) err_d = 1'b1;
        ans_d = err_d ? ERR_CODE : res_w[31:0];
    end

    always_ff @(posedge clock_50m or negedge rst) begin
        if (!rst) begin
            ans_q       <= 32'd0;
            err_q       <= 1'b0;
            ans_valid_q <= 1'b0;
        end else begin
            ans_valid_q <= bus.cal_enable;
            if (bus.cal_enable) begin
                ans_q <= ans_d;
                err_q <= err_d;
            end
        end
    end

    assign bus.ans       = ans_q;
    assign bus.err       = err_q;
    assign bus.ans_valid = ans_valid_q;

endmodule
`default_nettype wire

// File: rtl/calc_keypad_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_keypad_alu : clock divider, debounced keypad encoder and ALU front-end
// rev 1.0
// ---------------------------------------------------------------------------
module calc_keypad_alu #(
    parameter int          SW_DIV_LOG2  = 21,
    parameter int          FND_DIV_LOG2 = 17,
    parameter logic [31:0] ERR_CODE     = calc_pkg::ERR_CODE
) (
    input  wire logic          clock_50m,
    input  wire logic          rst,
    input  wire logic [15:0]   pb,
    calc_keypad_alu_if.slave   bus,
    output logic               sw_clk,
    output logic               fnd_clk,
    output logic               sw_tick,
    output logic               fnd_tick,
    output logic [4:0]         eBCD,
    output logic               clr_req
);
    import calc_pkg::*;

    logic [SW_DIV_LOG2-1:0] cnt_q;
    logic [SW_DIV_LOG2-1:0] cnt_d;
    logic [15:0]            key_q;
    logic [15:0]            key_d;
    logic [4:0]             ebcd_q;
    logic [4:0]             ebcd_d;
    logic                   clr_q;
    logic                   clr_d;
    logic [15:0]            sample_w;
    logic                   press_w;

    assign cnt_d    = cnt_q + {{(SW_DIV_LOG2-1){1'b0}}, 1'b1};
    assign sw_tick  = &cnt_q;
    assign fnd_tick = &cnt_q[FND_DIV_LOG2-1:0];
    assign sw_clk   = cnt_q[SW_DIV_LOG2-1];
    assign fnd_clk  = cnt_q[FND_DIV_LOG2-1];

    // The slow sample tick is the debounce: only released-to-pressed transitions count.
    assign sample_w = ~pb;
    assign press_w  = sw_tick && (|sample_w) && !(|key_q);

    always_comb begin
        key_d  = key_q;
        ebcd_d = KEY_NONE;
        clr_d  = 1'b0;
        if (sw_tick) key_d = sample_w;
        if (press_w) begin
            if (sample_w[14] && sample_w[15]) clr_d  = 1'b1;
            else                              ebcd_d = encode_keys(sample_w);
        end
    end

    always_ff @(posedge clock_50m or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            key_q  <= 16'd0;
            ebcd_q <= KEY_NONE;
            clr_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            key_q  <= key_d;
            ebcd_q <= ebcd_d;
            clr_q  <= clr_d;
        end
    end

    assign eBCD    = ebcd_q;
    assign clr_req = clr_q;

    calc_alu #(
        .ERR_CODE (ERR_CODE)
    ) u_alu (
        .clock_50m (clock_50m),
        .rst       (rst),
        .bus       (bus)
    );

endmodule
`default_nettype wire

// File: tb/tb_calc_keypad_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_calc_keypad_alu : directed self-checking bench for calc_keypad_alu
// rev 1.0
// ---------------------------------------------------------------------------
module tb_calc_keypad_alu;

    localparam logic [31:0] ERRC = 32'h00EE_0000;

    typedef struct {
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic        [2:0]  op;
        logic signed [31:0] exp_ans;
        logic               exp_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] pb;
    logic        sw_clk, fnd_clk, sw_tick, fnd_tick, clr_req;
    logic [4:0]  eBCD;

    int n_cmp  = 0;
    int n_fail = 0;

    calc_keypad_alu_if bus ();

    calc_keypad_alu #(
        .SW_DIV_LOG2  (4),
        .FND_DIV_LOG2 (2),
        .ERR_CODE     (ERRC)
    ) dut (
        .clock_50m (clk),
        .rst       (rst),
        .pb        (pb),
        .bus       (bus),
        .sw_clk    (sw_clk),
        .fnd_clk   (fnd_clk),
        .sw_tick   (sw_tick),
        .fnd_tick  (fnd_tick),
        .eBCD      (eBCD),
        .clr_req   (clr_req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst = 1'b0;
        pb  = 16'hFFFF;
        bus.operand1 = 32'sd0; bus.operand2 = 32'sd0;
        bus.operator = 3'd0;   bus.cal_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({sw_clk, fnd_clk, sw_tick, fnd_tick, clr_req, eBCD} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_front: got %b required 0", {sw_clk, fnd_clk, sw_tick, fnd_tick, clr_req, eBCD});
        end
        n_cmp++;
        if ({bus.ans, bus.ans_valid, bus.err} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_alu: ans=%0d valid=%b err=%b required 0/0/0", bus.ans, bus.ans_valid, bus.err);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Counter model restarts at zero on reset release; first posedge makes it 1.
    task automatic test_divider();
        int m = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            m++;
            n_cmp++;
            if (sw_tick !== ((m % 16) == 15) || fnd_tick !== ((m % 4) == 3) ||
                sw_clk !== (((m >> 3) & 1) == 1) || fnd_clk !== (((m >> 1) & 1) == 1)) begin
                n_fail++;
                $display("FAIL divider cycle %0d: sw_tick=%b fnd_tick=%b sw_clk=%b fnd_clk=%b required %b %b %b %b",
                         m, sw_tick, fnd_tick, sw_clk, fnd_clk, (m % 16) == 15, (m % 4) == 3,
                         ((m >> 3) & 1) == 1, ((m >> 1) & 1) == 1);
            end
        end
    endtask

    task automatic test_keypad_walk();
        logic [4:0] codes [16];
        codes = '{5'h11, 5'h12, 5'h13, 5'h1B, 5'h14, 5'h15, 5'h16, 5'h1A,
                  5'h17, 5'h18, 5'h19, 5'h1D, 5'h1C, 5'h10, 5'h1E, 5'h1F};
        for (int k = 0; k < 16; k++) begin
            logic       found;
            logic       prev;
            logic [4:0] got;
            int         extra;
            @(negedge clk);
            pb    = ~(16'h0001 << k);
            prev  = sw_tick;
            found = 1'b0;
            got   = 5'h00;
            for (int c = 0; c < 40 && !found; c++) begin
                @(posedge clk); #1;
                if (eBCD !== 5'h00) begin found = 1'b1; got = eBCD; end
                else prev = sw_tick;
            end
            n_cmp++;
            if (!found || got !== codes[k] || prev !== 1'b1) begin
                n_fail++;
                $display("FAIL key_press pb[%0d]: got %h (found=%b after_tick=%b) required %h", k, got, found, prev, codes[k]);
            end
            extra = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                if (eBCD !== 5'h00 || clr_req !== 1'b0) extra++;
            end
            @(negedge clk);
            pb = 16'hFFFF;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                if (eBCD !== 5'h00 || clr_req !== 1'b0) extra++;
            end
            n_cmp++;
            if (extra !== 0) begin
                n_fail++;
                $display("FAIL key_hold_release pb[%0d]: got %0d extra active cycles required 0", k, extra);
            end
        end
    endtask

    task automatic test_clear();
        logic found = 1'b0;
        logic [4:0] code_at_clr = 5'h00;
        int extra = 0;
        @(negedge clk);
        pb = 16'h3FFF;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            if (clr_req === 1'b1) begin found = 1'b1; code_at_clr = eBCD; end
            else if (eBCD !== 5'h00) extra++;
        end
        n_cmp++;
        if (!found || code_at_clr !== 5'h00 || extra !== 0) begin
            n_fail++;
            $display("FAIL clear_req: found=%b eBCD=%h stray=%0d required 1/00/0", found, code_at_clr, extra);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (clr_req !== 1'b0 || eBCD !== 5'h00) extra++;
        end
        @(negedge clk);
        pb = 16'hFFFF;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (clr_req !== 1'b0 || eBCD !== 5'h00) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL clear_width: got %0d extra active cycles required 0", extra);
        end
    endtask

    task automatic test_alu_vectors();
        vec_t v [27];
        v = '{
            '{ 32'sd10,      32'sd101, 3'd3,  32'sd111,      1'b0},
            '{ 32'sd10,      32'sd101, 3'd4, -32'sd91,       1'b0},
            '{ 32'sd10,      32'sd101, 3'd1,  32'sd1010,     1'b0},
            '{ 32'sd10,      32'sd101, 3'd2,  32'sd0,        1'b0},
            '{ 32'sd10,      32'sd101, 3'd5,  32'sd10,       1'b0},
            '{-32'sd10,     -32'sd101, 3'd3, -32'sd111,      1'b0},
            '{-32'sd10,     -32'sd101, 3'd4,  32'sd91,       1'b0},
            '{-32'sd10,     -32'sd101, 3'd1,  32'sd1010,     1'b0},
            '{-32'sd10,     -32'sd101, 3'd2,  32'sd0,        1'b0},
            '{-32'sd10,     -32'sd101, 3'd5, -32'sd10,       1'b0},
            '{ 32'sd100000, -32'sd500, 3'd3,  32'sd99500,    1'b0},
            '{ 32'sd100000, -32'sd500, 3'd4,  32'sd100500,   1'b0},
            '{ 32'sd100000, -32'sd500, 3'd1,  32'sh00EE0000, 1'b1},
            '{ 32'sd100000, -32'sd500, 3'd2, -32'sd200,      1'b0},
            '{ 32'sd100000, -32'sd500, 3'd5,  32'sd0,        1'b0},
            '{ 32'sd1023,    32'sd0,   3'd3,  32'sd1023,     1'b0},
            '{ 32'sd1023,    32'sd0,   3'd2,  32'sh00EE0000, 1'b1},
            '{ 32'sd1023,    32'sd0,   3'd5,  32'sh00EE0000, 1'b1},
            '{ 32'sd999999,  32'sd0,   3'd3,  32'sd999999,   1'b0},
            '{ 32'sd999999,  32'sd1,   3'd3,  32'sh00EE0000, 1'b1},
            '{-32'sd99999,   32'sd0,   3'd4, -32'sd99999,    1'b0},
            '{-32'sd99999,   32'sd1,   3'd4,  32'sh00EE0000, 1'b1},
            '{ 32'sd5,       32'sd3,   3'd0,  32'sh00EE0000, 1'b1},
            '{ 32'sd5,       32'sd3,   3'd7,  32'sh00EE0000, 1'b1},
            '{-32'sd7,       32'sd2,   3'd2, -32'sd3,        1'b0},
            '{-32'sd7,       32'sd2,   3'd5, -32'sd1,        1'b0},
            '{ 32'sd7,      -32'sd2,   3'd5,  32'sd1,        1'b0}
        };
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            bus.operand1   = v[i].a;
            bus.operand2   = v[i].b;
            bus.operator   = v[i].op;
            bus.cal_enable = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if (bus.ans !== v[i].exp_ans || bus.err !== v[i].exp_err || bus.ans_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL alu_vec %0d (%0d op%0d %0d): ans=%0d err=%b valid=%b required ans=%0d err=%b valid=1",
                         i, v[i].a, v[i].op, v[i].b, bus.ans, bus.err, bus.ans_valid, v[i].exp_ans, v[i].exp_err);
            end
            @(negedge clk);
            bus.cal_enable = 1'b0;
            bus.operator   = 3'd1;
            bus.operand1   = 32'sd3;
            @(posedge clk); #1;
            n_cmp++;
            if (bus.ans !== v[i].exp_ans || bus.ans_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL alu_hold %0d: ans=%0d valid=%b required ans=%0d valid=0", i, bus.ans, bus.ans_valid, v[i].exp_ans);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.operand1 = 32'sd10; bus.operand2 = 32'sd101;
        bus.operator = 3'd3;    bus.cal_enable = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.ans !== 32'sd111 || bus.ans_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: ans=%0d valid=%b required 111/1", bus.ans, bus.ans_valid);
        end
        @(negedge clk);
        bus.operator = 3'd4;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.ans !== -32'sd91 || bus.ans_valid !== 1'b1 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: ans=%0d valid=%b err=%b required -91/1/0", bus.ans, bus.ans_valid, bus.err);
        end
        @(negedge clk);
        bus.cal_enable = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.ans !== -32'sd91 || bus.ans_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_last_wins: ans=%0d valid=%b required -91/0", bus.ans, bus.ans_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        int extra = 0;
        @(negedge clk);
        pb = 16'hFFFE;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (sw_tick === 1'b1) seen = 1'b1;
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (!seen || {sw_clk, fnd_clk, sw_tick, fnd_tick, clr_req, eBCD} !== 10'd0 ||
            {bus.ans, bus.ans_valid, bus.err} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_mid: tick_seen=%b front=%b ans=%0d valid=%b err=%b required 1/0/0/0/0",
                     seen, {sw_clk, fnd_clk, sw_tick, fnd_tick, clr_req, eBCD}, bus.ans, bus.ans_valid, bus.err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        pb  = 16'hFFFF;
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (eBCD !== 5'h00 || clr_req !== 1'b0 || bus.ans !== 32'sd0) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %0d cycles with activity required 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_keypad_walk();
        test_clear();
        test_alu_vectors();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
